robot_sprite_renderer: RTL and testbench
========================================

Name: robot_sprite_renderer

Overview:
- Parametrised successor to the robot icon generator: draws an animated, orientation-dependent sprite of the Rojobot over the world map.
- Fixes pixel-path timing. Multiplications move to a once-per-frame latch, and the pixel path is a fixed-latency pipeline aligned to an external sprite RAM.
- Adds tear-free frame/orientation updates, selectable animation mode, and speed-scaled animation rate.
- Sits between the DTG pixel counters and the colorizer, alongside the world map block.

Parameters:
- SCALING_FACTOR, 6, screen pixels per world cell
- MARGIN, 128, horizontal screen offset of the world map
- SPRITE_COLS, 34, sprite width in pixels
- SPRITE_ROWS, 34, sprite height in pixels
- NUM_FRAMES, 3, animation frames per orientation (1..8)
- ANIM_COUNTDOWN, 8_000_000, clocks per frame at speed 1
- ANIM_MODE, 0, 0 = ping-pong, 1 = wrap-around loop
- IDLE_FRAME, 1, frame shown while stopped (< NUM_FRAMES)
- RAM_LATENCY, 1, sprite RAM read latency in clocks (1..3)
- TRANSPARENT, 12'h000, colour emitted outside the sprite

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- pixel_row  in  12  current screen row
- pixel_column  in  12  current screen column
- pixel_valid  in  1  row/column valid this cycle
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- LocX_reg  in  8  robot world X
- LocY_reg  in  8  robot world Y
- BotInfo_reg  in  8  [7:4] speed, [2:0] orientation
- ram_addr  out  32  sprite RAM read address
- ram_data  in  12  sprite RAM read data, RAM_LATENCY clocks after ram_addr
- icon  out  12  pixel colour
- icon_valid  out  1  icon corresponds to a pixel_valid input

Behaviour:
- Reset (asynchronous, active-high) clears everything:
  - icon = 0, icon_valid = 0, ram_addr = 0, all pipeline valids = 0.
  - Latched left/top = 0; latched orient_row = 0.
  - frame_next = frame_disp = IDLE_FRAME, direction = +1, counter = ANIM_COUNTDOWN.
- Derived constants:
  - MEM_COLS = SPRITE_COLS*NUM_FRAMES.
  - FRAME_ROW_SIZE = MEM_COLS*SPRITE_ROWS.
  - CX = (SPRITE_COLS-SCALING_FACTOR)/2, CY = (SPRITE_ROWS-SCALING_FACTOR)/2.
- Frame latch: on frame_start, register the following. All arithmetic is signed 14-bit and may be negative.
  - left = LocX_reg*SCALING_FACTOR - CX.
  - top = LocY_reg*SCALING_FACTOR - CY.
  - orient_row from BotInfo_reg[2:0]: 0→1, 1→7, 2→3, 3→5, 4→0, 5→4, 6→2, 7→6.
  - frame_disp = frame_next.
- Pixel pipeline (one pixel accepted per cycle, no stalls):
  - S1: register x = pixel_column - MARGIN - left and y = pixel_row - top, plus valid.
  - S2: hit = (0 <= x < SPRITE_COLS) && (0 <= y < SPRITE_ROWS). Register ram_addr = orient_row*FRAME_ROW_SIZE + frame_disp*SPRITE_COLS + y*MEM_COLS + x; hold the previous ram_addr on a miss. Delay hit and valid through RAM_LATENCY stages.
  - Output: icon = hit ? ram_data : TRANSPARENT; icon_valid = delayed valid.
  - Total latency from pixel_valid to icon_valid is 2 + RAM_LATENCY clocks.
- frame_start coincident with pixel_valid: that pixel uses the old latched values; the new values apply from the next accepted pixel.
- Animation FSM (free-running; updates frame_next only):
  - States: IDLE, RUN_FWD, RUN_REV.
  - IDLE: entered when speed == 0. frame_next = IDLE_FRAME, counter reloaded.
  - IDLE→RUN_FWD when speed != 0.
  - RUN_*: counter decrements. Reload = ANIM_COUNTDOWN >> min(speed-1, 3).
  - At counter == 0, step frame_next by ±1 and reload.
  - Ping-pong mode: in RUN_FWD, reaching NUM_FRAMES-1 goes to RUN_REV; in RUN_REV, reaching 0 goes to RUN_FWD.
  - Loop mode: stays in RUN_FWD; NUM_FRAMES-1 wraps to 0.
  - NUM_FRAMES == 1: frame_next is always 0.
  - speed → 0 mid-count: go to IDLE on the next clock, discarding the count.
- Reset mid-line: in-flight pixels are dropped; icon_valid stays low until new pixels traverse the pipeline.

Test Plan:
- Reset mid-stream with pixel_valid high → icon = 0 and icon_valid = 0 immediately; first icon_valid appears 3 clocks after the first pixel following release (RAM_LATENCY = 1).
- Defaults; LocX = 10, LocY = 20, BotInfo = 8'h02 (E, stopped); pulse frame_start; pixel (row 106, col 174) → left = 46, top = 106, ram_addr = 3*3468 + 1*34 + 0 + 0 = 10438; icon = ram_data 3 clocks later.
- Same setup, pixels at col 173 and col 208 (x = -1 and x = 34) → icon = 12'h000 with icon_valid = 1; ram_addr unchanged.
- BotInfo = 8'h10, ANIM_COUNTDOWN = 4, ping-pong → frame_next sequence 1, 2, 1, 0, 1, 2 every 5 clocks; frame_disp changes only on frame_start pulses.
- ANIM_MODE = 1, speed = 3, ANIM_COUNTDOWN = 8 → reload = 2; frame_next cycles 1, 2, 0, 1 every 3 clocks; set speed = 0 → frame_next = 1 next clock.
- Change LocX and orientation mid-frame without frame_start → rendered address is unchanged until the next frame_start; a pixel coincident with frame_start uses the old values.

Source files
------------

// File: rtl/robot_sprite_renderer.sv
// Rojobot sprite renderer: per-frame latched placement/orientation, fixed-latency
// pixel pipeline into an external sprite RAM, and a speed-scaled animation FSM.
module robot_sprite_renderer #(
  parameter int          SCALING_FACTOR = 6,
  parameter int          MARGIN         = 128,
  parameter int          SPRITE_COLS    = 34,
  parameter int          SPRITE_ROWS    = 34,
  parameter int          NUM_FRAMES     = 3,
  parameter int          ANIM_COUNTDOWN = 8_000_000,
  parameter int          ANIM_MODE      = 0,
  parameter int          IDLE_FRAME     = 1,
  parameter int          RAM_LATENCY    = 1,
  parameter logic [11:0] TRANSPARENT    = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  input  logic        pixel_valid,
  input  logic        frame_start,
  input  logic [7:0]  LocX_reg,
  input  logic [7:0]  LocY_reg,
  input  logic [7:0]  BotInfo_reg,
  output logic [31:0] ram_addr,
  input  logic [11:0] ram_data,
  output logic [11:0] icon,
  output logic        icon_valid,
  output logic [1:0]  dbg_state_o,
  output logic [2:0]  dbg_frame_next_o,
  output logic [2:0]  dbg_frame_disp_o
);

  localparam int MEM_COLS       = SPRITE_COLS * NUM_FRAMES;
  localparam int FRAME_ROW_SIZE = MEM_COLS * SPRITE_ROWS;
  localparam int CX             = (SPRITE_COLS - SCALING_FACTOR) / 2;
  localparam int CY             = (SPRITE_ROWS - SCALING_FACTOR) / 2;
  localparam logic [2:0] IDLE_F = 3'(IDLE_FRAME);
  localparam logic [2:0] LAST_F = 3'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_FWD = 2'd1,
    ST_RUN_REV = 2'd2
  } anim_state_e;

  // ---------------- frame latch ----------------
  logic [13:0] left_q, top_q;
  logic [2:0]  orient_row_q, orient_row_d;
  logic [2:0]  frame_disp_q;
  logic [31:0] base_q, base_d;
  logic [2:0]  frame_next_q, frame_next_d;

  logic signed [31:0] left_full, top_full;
  assign left_full = $signed({24'd0, LocX_reg}) * SCALING_FACTOR - CX;
  assign top_full  = $signed({24'd0, LocY_reg}) * SCALING_FACTOR - CY;

  always_comb begin
    orient_row_d = 3'd0;
    case (BotInfo_reg[2:0])
      3'd0: orient_row_d = 3'd1;
      3'd1: orient_row_d = 3'd7;
      3'd2: orient_row_d = 3'd3;
      3'd3: orient_row_d = 3'd5;
      3'd4: orient_row_d = 3'd0;
      3'd5: orient_row_d = 3'd4;
      3'd6: orient_row_d = 3'd2;
      default: orient_row_d = 3'd6;
    endcase
  end

  // Orientation/frame base offset is folded once per frame so the pixel path only adds.
  assign base_d = 32'(orient_row_d) * 32'(FRAME_ROW_SIZE)
                + 32'(frame_next_q) * 32'(SPRITE_COLS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_q       <= '0;
      top_q        <= '0;
      orient_row_q <= '0;
      frame_disp_q <= IDLE_F;
      base_q       <= 32'(IDLE_FRAME) * 32'(SPRITE_COLS);
    end else if (frame_start) begin
      left_q       <= left_full[13:0];
      top_q        <= top_full[13:0];
      orient_row_q <= orient_row_d;
      frame_disp_q <= frame_next_q;
      base_q       <= base_d;
    end
  end

  // ---------------- pixel pipeline ----------------
  logic [13:0] s1_x_q, s1_y_q;
  logic [31:0] s1_base_q;
  logic        s1_valid_q;
  logic        s2_hit_q, s2_valid_q;
  logic [31:0] ram_addr_q;
  logic [RAM_LATENCY-1:0] hit_pipe_q, vld_pipe_q;

  logic        s1_hit;
  logic [31:0] s1_addr;

  assign s1_hit = !s1_x_q[13] && (s1_x_q < 14'(SPRITE_COLS)) &&
                  !s1_y_q[13] && (s1_y_q < 14'(SPRITE_ROWS));
  assign s1_addr = s1_base_q + 32'(s1_y_q) * 32'(MEM_COLS) + 32'(s1_x_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_base_q  <= '0;
      s1_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      ram_addr_q <= '0;
      hit_pipe_q <= '0;
      vld_pipe_q <= '0;
    end else begin
      // Sampling the latch registers here keeps a frame_start-coincident pixel on old values.
      s1_x_q     <= {2'b00, pixel_column} - 14'(MARGIN) - left_q;
      s1_y_q     <= {2'b00, pixel_row} - top_q;
      s1_base_q  <= base_q;
      s1_valid_q <= pixel_valid;
      s2_hit_q   <= s1_valid_q && s1_hit;
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q && s1_hit) ram_addr_q <= s1_addr;
      hit_pipe_q[0] <= s2_hit_q;
      vld_pipe_q[0] <= s2_valid_q;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        hit_pipe_q[i] <= hit_pipe_q[i-1];
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
  end

  assign ram_addr   = ram_addr_q;
  assign icon_valid = vld_pipe_q[RAM_LATENCY-1];
  assign icon       = !vld_pipe_q[RAM_LATENCY-1] ? 12'h000 :
                      hit_pipe_q[RAM_LATENCY-1] ? ram_data : TRANSPARENT;

  // ---------------- animation FSM ----------------
  anim_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  speed;
  logic [1:0]  shift;
  logic [31:0] reload;

  assign speed = BotInfo_reg[7:4];

  always_comb begin
    shift = 2'd0;
    if (speed >= 4'd4)      shift = 2'd3;
    else if (speed != 4'd0) shift = 2'(speed - 4'd1);
  end

  assign reload = 32'(ANIM_COUNTDOWN) >> shift;

  always_comb begin
    state_d      = state_q;
    frame_next_d = frame_next_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        frame_next_d = IDLE_F;
        cnt_d        = reload;
        if (speed != 4'd0) state_d = ST_RUN_FWD;
      end
      ST_RUN_FWD, ST_RUN_REV: begin
        if (speed == 4'd0) begin
          state_d      = ST_IDLE;
          frame_next_d = IDLE_F;
          cnt_d        = reload;
        end else if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          cnt_d = reload;
          if (NUM_FRAMES == 1) begin
            frame_next_d = 3'd0;
          end else if (ANIM_MODE == 1) begin
            state_d      = ST_RUN_FWD;
            frame_next_d = (frame_next_q >= LAST_F) ? 3'd0 : frame_next_q + 3'd1;
          end else if (state_q == ST_RUN_FWD) begin
            // Direction flips as soon as the end frame is reached, not one step later.
            if (frame_next_q >= LAST_F) begin
              frame_next_d = frame_next_q - 3'd1;
              state_d      = (frame_next_d == 3'd0) ? ST_RUN_FWD : ST_RUN_REV;
            end else begin
              frame_next_d = frame_next_q + 3'd1;
              state_d      = (frame_next_d == LAST_F) ? ST_RUN_REV : ST_RUN_FWD;
            end
          end else begin
            if (frame_next_q == 3'd0) begin
              frame_next_d = 3'd1;
              state_d      = (frame_next_d == LAST_F) ? ST_RUN_REV : ST_RUN_FWD;
            end else begin
              frame_next_d = frame_next_q - 3'd1;
              state_d      = (frame_next_d == 3'd0) ? ST_RUN_FWD : ST_RUN_REV;
            end
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        frame_next_d = IDLE_F;
        cnt_d        = reload;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_next_q <= IDLE_F;
      cnt_q        <= 32'(ANIM_COUNTDOWN);
    end else begin
      state_q      <= state_d;
      frame_next_q <= frame_next_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dbg_state_o      = state_q;
  assign dbg_frame_next_o = frame_next_q;
  assign dbg_frame_disp_o = frame_disp_q;

  logic unused_bits;
  assign unused_bits = ^{BotInfo_reg[3], left_full[31:14], top_full[31:14], orient_row_q};

endmodule

// File: tb/tb_robot_sprite_renderer.sv
// Directed bench for robot_sprite_renderer: pixel placement/addressing vectors,
// reset behaviour, frame-latch timing and both animation modes.
module tb_robot_sprite_renderer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- main instance (default parameters) ----------------
  logic [11:0] pixel_row = '0, pixel_column = '0;
  logic        pixel_valid = 1'b0, frame_start = 1'b0;
  logic [7:0]  loc_x = '0, loc_y = '0, bot_info = '0;
  logic [31:0] ram_addr;
  logic [11:0] ram_data = '0;
  logic [11:0] icon;
  logic        icon_valid;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_fn, dbg_fd;

  robot_sprite_renderer dut (
    .clk(clk), .reset(reset),
    .pixel_row(pixel_row), .pixel_column(pixel_column),
    .pixel_valid(pixel_valid), .frame_start(frame_start),
    .LocX_reg(loc_x), .LocY_reg(loc_y), .BotInfo_reg(bot_info),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .icon(icon), .icon_valid(icon_valid),
    .dbg_state_o(dbg_state), .dbg_frame_next_o(dbg_fn), .dbg_frame_disp_o(dbg_fd)
  );

  function automatic logic [11:0] ram_f(logic [31:0] a);
    return a[11:0] ^ 12'h5A3;
  endfunction

  always @(posedge clk) ram_data <= ram_f(ram_addr);

  // ---------------- ping-pong animation instance ----------------
  logic [11:0] zero12 = '0;
  logic        fs_pp = 1'b0;
  logic [7:0]  bot_pp = '0;
  logic [31:0] pp_addr;
  logic [11:0] pp_icon;
  logic        pp_iv;
  logic [1:0]  pp_state;
  logic [2:0]  pp_fn, pp_fd;

  robot_sprite_renderer #(.ANIM_COUNTDOWN(4), .ANIM_MODE(0)) dut_pp (
    .clk(clk), .reset(reset),
    .pixel_row(zero12), .pixel_column(zero12),
    .pixel_valid(1'b0), .frame_start(fs_pp),
    .LocX_reg(8'd0), .LocY_reg(8'd0), .BotInfo_reg(bot_pp),
    .ram_addr(pp_addr), .ram_data(zero12),
    .icon(pp_icon), .icon_valid(pp_iv),
    .dbg_state_o(pp_state), .dbg_frame_next_o(pp_fn), .dbg_frame_disp_o(pp_fd)
  );

  // ---------------- loop animation instance ----------------
  logic [7:0]  bot_lp = '0;
  logic [31:0] lp_addr;
  logic [11:0] lp_icon;
  logic        lp_iv;
  logic [1:0]  lp_state;
  logic [2:0]  lp_fn, lp_fd;

  robot_sprite_renderer #(.ANIM_COUNTDOWN(8), .ANIM_MODE(1)) dut_lp (
    .clk(clk), .reset(reset),
    .pixel_row(zero12), .pixel_column(zero12),
    .pixel_valid(1'b0), .frame_start(1'b0),
    .LocX_reg(8'd0), .LocY_reg(8'd0), .BotInfo_reg(bot_lp),
    .ram_addr(lp_addr), .ram_data(zero12),
    .icon(lp_icon), .icon_valid(lp_iv),
    .dbg_state_o(lp_state), .dbg_frame_next_o(lp_fn), .dbg_frame_disp_o(lp_fd)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pixel was sampled at the edge before the call; check S2 address then the output.
  task automatic check_result(input string name, input logic hit, input logic [31:0] addr);
    @(negedge clk);
    chk({name, "_addr"}, ram_addr, addr);
    chk({name, "_iv_early"}, 32'(icon_valid), 32'd0);
    @(negedge clk);
    chk({name, "_iv"}, 32'(icon_valid), 32'd1);
    chk({name, "_icon"}, 32'(icon), hit ? 32'(ram_f(addr)) : 32'd0);
  endtask

  task automatic send_pixel(input string name, input logic [11:0] row, input logic [11:0] col,
                            input logic hit, input logic [31:0] addr);
    @(negedge clk);
    pixel_valid = 1'b1; pixel_row = row; pixel_column = col;
    @(negedge clk);
    pixel_valid = 1'b0;
    check_result(name, hit, addr);
  endtask

  task automatic pulse_fs;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [11:0] row;
    logic [11:0] col;
    logic        hit;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    logic found;
    logic [2:0] seq_pp[4];
    logic [2:0] prev;

    // LocX=10, LocY=20, east: left=46, top=106, base=3*3468+1*34=10438
    vecs[0] = '{"origin",     12'd106, 12'd174, 1'b1, 32'd10438};
    vecs[1] = '{"x_minus1",   12'd106, 12'd173, 1'b0, 32'd10438};
    vecs[2] = '{"x_34",       12'd106, 12'd208, 1'b0, 32'd10438};
    vecs[3] = '{"x_33",       12'd106, 12'd207, 1'b1, 32'd10471};
    vecs[4] = '{"y_33",       12'd139, 12'd174, 1'b1, 32'd13804};
    vecs[5] = '{"y_34",       12'd140, 12'd174, 1'b0, 32'd13804};
    vecs[6] = '{"y_minus1",   12'd105, 12'd190, 1'b0, 32'd13804};
    vecs[7] = '{"corner",     12'd139, 12'd207, 1'b1, 32'd13837};
    vecs[8] = '{"interior",   12'd120, 12'd180, 1'b1, 32'd11872};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_icon", 32'(icon), 32'd0);
    chk("rst_iv", 32'(icon_valid), 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_fn", 32'(dbg_fn), 32'd1);
    chk("rst_fd", 32'(dbg_fd), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // ---- reset mid-stream ----
    pixel_valid = 1'b1; pixel_row = 12'd0; pixel_column = 12'd128;
    repeat (5) @(negedge clk);
    chk("stream_iv", 32'(icon_valid), 32'd1);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("midrst_icon", 32'(icon), 32'd0);
    chk("midrst_iv", 32'(icon_valid), 32'd0);
    chk("midrst_addr", ram_addr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_iv_1", 32'(icon_valid), 32'd0);
    @(negedge clk);
    chk("rel_iv_2", 32'(icon_valid), 32'd0);
    chk("rel_addr", ram_addr, 32'd34);
    @(negedge clk);
    chk("rel_iv_3", 32'(icon_valid), 32'd1);
    chk("rel_icon", 32'(icon), 32'(ram_f(32'd34)));
    pixel_valid = 1'b0;
    repeat (4) @(negedge clk);

    // ---- placement table ----
    loc_x = 8'd10; loc_y = 8'd20; bot_info = 8'h02;
    pulse_fs();
    for (int i = 0; i < 9; i++)
      send_pixel(vecs[i].name, vecs[i].row, vecs[i].col, vecs[i].hit, vecs[i].addr);

    // ---- mid-frame changes wait for frame_start ----
    loc_x = 8'd20; bot_info = 8'h04;
    send_pixel("no_fs", 12'd106, 12'd174, 1'b1, 32'd10438);
    @(negedge clk);
    frame_start = 1'b1; pixel_valid = 1'b1; pixel_row = 12'd106; pixel_column = 12'd174;
    @(negedge clk);
    frame_start = 1'b0; pixel_valid = 1'b0;
    check_result("fs_coincident", 1'b1, 32'd10438);
    // left=106, top=106, north row 0, frame 1 -> 34 + 102 + 1
    send_pixel("after_fs", 12'd107, 12'd235, 1'b1, 32'd137);

    // ---- ping-pong animation ----
    seq_pp[0] = 3'd1; seq_pp[1] = 3'd0; seq_pp[2] = 3'd1; seq_pp[3] = 3'd2;
    @(negedge clk);
    bot_pp = 8'h10;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (pp_fn == 3'd2) found = 1'b1;
    end
    chk("pp_reach2", 32'(found), 32'd1);
    chk("pp_state_rev", 32'(pp_state), 32'd2);
    prev = 3'd2;
    for (int s = 0; s < 4; s++) begin
      for (int h = 0; h < 4; h++) begin
        @(negedge clk);
        chk("pp_hold", 32'(pp_fn), 32'(prev));
      end
      @(negedge clk);
      chk("pp_step", 32'(pp_fn), 32'(seq_pp[s]));
      chk("pp_disp_held", 32'(pp_fd), 32'd1);
      prev = seq_pp[s];
    end
    fs_pp = 1'b1;
    @(negedge clk);
    fs_pp = 1'b0;
    chk("pp_disp_latch", 32'(pp_fd), 32'd2);

    // ---- loop animation: reload 8>>2 = 2 ----
    bot_lp = 8'h30;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (lp_fn == 3'd2) found = 1'b1;
    end
    chk("lp_reach2", 32'(found), 32'd1);
    prev = 3'd2;
    for (int s = 0; s < 3; s++) begin
      for (int h = 0; h < 2; h++) begin
        @(negedge clk);
        chk("lp_hold", 32'(lp_fn), 32'(prev));
      end
      @(negedge clk);
      prev = (prev == 3'd2) ? 3'd0 : prev + 3'd1;
      chk("lp_step", 32'(lp_fn), 32'(prev));
      chk("lp_state_fwd", 32'(lp_state), 32'd1);
    end
    bot_lp = 8'h00;
    @(negedge clk);
    chk("lp_stop_fn", 32'(lp_fn), 32'd1);
    chk("lp_stop_state", 32'(lp_state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
